// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter (and the future receiver).
// Optional feature macro: UART_TX_BREAK_EN adds the BREAK state.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
`ifdef UART_TX_BREAK_EN
        , BREAK
`endif
    } uart_state_e;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    localparam int MIN_DATA_BITS = 5;

    // Requested character length forced into the legal MIN..max_bits window.
    function automatic int clamp_len(input int cfg, input int max_bits);
        if (cfg < MIN_DATA_BITS) return MIN_DATA_BITS;
        if (cfg > max_bits)      return max_bits;
        return cfg;
    endfunction

    // Codes 5..7 behave as "no parity".
    function automatic logic parity_on(input logic [2:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD) ||
               (mode == PAR_MARK) || (mode == PAR_SPACE);
    endfunction

    // Bit periods in one frame: start + data + optional parity + stop bits.
    function automatic int frame_len(input int len, input logic [2:0] mode,
                                     input logic stop2);
        return 1 + len + (parity_on(mode) ? 1 : 0) + (stop2 ? 2 : 1);
    endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Parity bit for a character of runtime length; shared by UART TX and RX.
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = 9
) (
    input  logic [MAX_DATA_BITS-1:0] data,
    input  logic [3:0]               len,
    input  logic [2:0]               mode,
    output logic                     parity
);

    logic xor_all;

    // XOR of the low 'len' bits, then mode select.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
        xor_all = 1'b0;
        parity  = 1'b0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < int'(len)) xor_all = xor_all ^ data[i];
        end
        case (mode)
            PAR_EVEN: parity = xor_all;
            PAR_ODD:  parity = ~xor_all;
            PAR_MARK: parity = 1'b1;
            default:  parity = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..MAX_DATA_BITS data, parity, 1/2 stop bits.
// Optional feature macro: UART_TX_BREAK_EN adds the send_break input and BREAK state.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int   MAX_DATA_BITS = 9,
    parameter logic DEFAULT_IDLE  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     baud_tick,
    input  logic [MAX_DATA_BITS-1:0] data_in,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic [3:0]               cfg_data_bits,
    input  logic [2:0]               cfg_parity,
    input  logic                     cfg_stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                     send_break,
`endif
    output logic                     tx,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = $clog2(MAX_DATA_BITS + 1);

    uart_state_e              state;
    logic [MAX_DATA_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]         bit_cnt;
    logic                     stop_cnt;
    logic [3:0]               len_q;
    logic                     par_en_q;
    logic                     par_bit_q;
    logic                     stop2_q;
    logic                     tx_q;
    logic                     done_q;
`ifdef UART_TX_BREAK_EN
    logic [3:0]               brk_cnt;
`endif

    int         acc_len_i;
    logic [3:0] acc_len;
    logic       acc_par;

    assign acc_len_i = clamp_len(int'(cfg_data_bits), MAX_DATA_BITS);
    assign acc_len   = 4'(acc_len_i);

    uart_parity_gen #(.MAX_DATA_BITS(MAX_DATA_BITS)) u_parity (
        .data   (data_in),
        .len    (acc_len),
        .mode   (cfg_parity),
        .parity (acc_par)
    );

    // tx_ready is forced low while reset is asserted, independent of state.
    assign tx_ready = (state == IDLE) && enable && rst_n;
    assign busy     = (state != IDLE);
    assign tx       = tx_q;
    assign done     = done_q;

    // Frame FSM; tx is a registered decode of the current state, so it follows one cycle after entry.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            len_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= DEFAULT_IDLE;
            done_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_cnt   <= '0;
`endif
        end else if (!enable) begin
            // Abort: the in-flight character is dropped without a done pulse.
            state    <= IDLE;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx_q     <= DEFAULT_IDLE;
            done_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_cnt  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q <= DEFAULT_IDLE;
`ifdef UART_TX_BREAK_EN
                    if (send_break) begin
                        state   <= BREAK;
                        brk_cnt <= 4'(frame_len(acc_len_i, cfg_parity, cfg_stop2));
                    end else
`endif
                    if (tx_valid) begin
                        // A tick in this same cycle is not seen by START.
                        state     <= START;
                        shift_reg <= data_in;
                        len_q     <= acc_len;
                        par_en_q  <= parity_on(cfg_parity);
                        par_bit_q <= acc_par;
                        stop2_q   <= cfg_stop2;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (baud_tick) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    tx_q <= shift_reg[0];
                    if (baud_tick) begin
                        shift_reg <= {1'b0, shift_reg[MAX_DATA_BITS-1:1]};
                        if (int'(bit_cnt) == int'(len_q) - 1) begin
                            bit_cnt  <= '0;
                            stop_cnt <= 1'b0;
                            state    <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    tx_q <= par_bit_q;
                    if (baud_tick) state <= STOP;
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (baud_tick) begin
                        if (stop2_q && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b0;
                            state    <= DONE;
                            done_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    tx_q  <= 1'b1;
                    state <= IDLE;
                end
`ifdef UART_TX_BREAK_EN
                BREAK: begin
                    // Hold low for at least one frame of ticks, then until send_break drops.
                    tx_q <= 1'b0;
                    if (baud_tick) begin
                        if (brk_cnt > 4'd1) begin
                            brk_cnt <= brk_cnt - 4'd1;
                        end else begin
                            brk_cnt <= '0;
                            if (!send_break) begin
                                state    <= STOP;
                                stop2_q  <= 1'b0;
                                stop_cnt <= 1'b0;
                            end
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: scoreboard of expected line bits, sampled on every baud tick.
module tb_uart_tx_cfg;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       tx_valid = 1'b0;
    logic [8:0] data_in = '0;
    logic [3:0] cfg_data_bits = 4'd8;
    logic [2:0] cfg_parity = PAR_NONE;
    logic       cfg_stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
    logic       send_break = 1'b0;
`endif
    logic       baud_tick, tx_ready, tx, busy, done;

    logic [3:0] div = '0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         done_cnt = 0;
    int         busy_cyc = 0;
    bit         mon_en = 1'b0;
    logic       exp_q[$];

    uart_tx_cfg #(.MAX_DATA_BITS(9), .DEFAULT_IDLE(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .baud_tick     (baud_tick),
        .data_in       (data_in),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
`ifdef UART_TX_BREAK_EN
        .send_break    (send_break),
`endif
        .tx            (tx),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // One tick every 16 clocks, high while div == 15.
    always @(posedge clk) div <= div + 4'd1;
    assign baud_tick = (div == 4'd15);

    // Scoreboard: the tick cycle closes a bit period, so tx there is that bit's value.
    always @(negedge clk) begin
        logic e;
        if (done) done_cnt++;
        if (busy) busy_cyc++;
        if (mon_en && baud_tick && busy) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL tx_bit: got %0b with empty scoreboard", tx);
            end else begin
                e = exp_q.pop_front();
                if (tx !== e) $display("FAIL tx_bit: got %0b expected %0b (%0d left)", tx, e, exp_q.size());
                else n_pass++;
            end
        end
    end

    // Expected line bits of one frame, built from the character and format.
    task automatic push_frame(input logic [8:0] d, input int bits, input logic [2:0] par, input bit stop2);
        int   len;
        logic x;
        len = (bits < 5) ? 5 : ((bits > 9) ? 9 : bits);
        x   = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(d[i]);
            x = x ^ d[i];
        end
        if (par == PAR_EVEN)  exp_q.push_back(x);
        if (par == PAR_ODD)   exp_q.push_back(~x);
        if (par == PAR_MARK)  exp_q.push_back(1'b1);
        if (par == PAR_SPACE) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        if (stop2) exp_q.push_back(1'b1);
    endtask

    // aligned: accept in a tick cycle (the tick must be ignored); otherwise accept as soon as ready.
    task automatic send(input logic [8:0] d, input int bits, input logic [2:0] par, input bit stop2, input bit aligned);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 1000 && !(tx_ready && (aligned ? (div == 4'd15) : (div != 4'd14))));
        n_checks++;
        if (n >= 1000) begin
            $display("FAIL send_wait: tx_ready=%0b after 1000 cycles, required 1", tx_ready);
            return;
        end
        data_in       = d;
        cfg_data_bits = 4'(bits);
        cfg_parity    = par;
        cfg_stop2     = stop2;
        tx_valid      = 1'b1;
        push_frame(d, bits, par, stop2);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        if (busy !== 1'b1) $display("FAIL accept: busy=%0b after accept, required 1", busy);
        else n_pass++;
    endtask

    // Returns #1 after the negedge where done is seen; DONE must show tx=1 and tx_ready=0.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 400 && done !== 1'b1);
        n_checks++;
        if (n >= 400) begin
            $display("FAIL %s_done: no done within 400 cycles", name);
            return;
        end
        if (tx !== 1'b1 || busy !== 1'b1 || tx_ready !== 1'b0)
            $display("FAIL %s_done_state: tx=%0b busy=%0b tx_ready=%0b, required 1 1 0", name, tx, busy, tx_ready);
        else n_pass++;
        #1;
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL %s_drain: %0d bits never sent, required 0", name, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        rst_n  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || tx_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_vals: tx=%0b ready=%0b busy=%0b done=%0b, required 1 0 0 0", tx, tx_ready, busy, done);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_ready !== 1'b1 || tx !== 1'b1) $display("FAIL reset_release: ready=%0b tx=%0b, required 1 1", tx_ready, tx);
        else n_pass++;
    endtask

    // 8N1 0xA5: accept in a tick cycle, so START is a full period: 10 periods + DONE = 161 busy cycles.
    task automatic test_8n1();
        int d0;
        mon_en   = 1'b1;
        d0       = done_cnt;
        busy_cyc = 0;
        send(9'h0A5, 8, PAR_NONE, 1'b0, 1'b1);
        wait_done("8n1");
        @(negedge clk);
        #1;
        n_checks++;
        if (busy_cyc != 161) $display("FAIL 8n1_busy_len: %0d cycles, required 161", busy_cyc);
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1 || done !== 1'b0) $display("FAIL 8n1_done_pulse: %0d pulses, required 1", done_cnt - d0);
        else n_pass++;
        check_drained("8n1");
    endtask

    task automatic test_formats();
        send(9'h1C1, 7, PAR_EVEN, 1'b1, 1'b1);   // upper bits 8:7 set, must not appear
        wait_done("7e2");
        check_drained("7e2");
        send(9'h1FF, 9, PAR_ODD, 1'b0, 1'b1);
        wait_done("9o1");
        send(9'h0B3, 3, PAR_NONE, 1'b0, 1'b1);   // clamps up to 5 bits
        wait_done("clamp_lo");
        send(9'h12D, 15, PAR_MARK, 1'b0, 1'b1);  // clamps down to 9 bits
        wait_done("clamp_hi");
        send(9'h0D2, 6, PAR_SPACE, 1'b1, 1'b1);
        wait_done("6s2");
        send(9'h055, 8, 3'd6, 1'b0, 1'b1);       // reserved code behaves as none
        wait_done("reserved_par");
        check_drained("formats");
    endtask

    task automatic test_cfg_midframe();
        send(9'h03C, 8, PAR_NONE, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        data_in       = 9'h1FF;
        cfg_data_bits = 4'd5;
        cfg_parity    = PAR_MARK;
        cfg_stop2     = 1'b1;
        wait_done("midcfg_a");
        send(9'h015, 5, PAR_MARK, 1'b1, 1'b1);
        wait_done("midcfg_b");
        check_drained("midcfg");
    endtask

    task automatic test_abort();
        int d0;
        mon_en = 1'b0;
        d0     = done_cnt;
        send(9'h00F, 8, PAR_NONE, 1'b0, 1'b1);
        exp_q.delete();
        repeat (88) @(negedge clk);               // inside data bit 4 (a 0)
        n_checks++;
        if (tx !== 1'b0 || busy !== 1'b1) $display("FAIL abort_pre: tx=%0b busy=%0b, required 0 1", tx, busy);
        else n_pass++;
        enable = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0)
            $display("FAIL abort_idle: tx=%0b busy=%0b ready=%0b, required 1 0 0", tx, busy, tx_ready);
        else n_pass++;
        repeat (40) @(negedge clk);
        enable = 1'b1;
        #1;
        n_checks++;
        if (tx_ready !== 1'b1 || done_cnt != d0) $display("FAIL abort_after: ready=%0b dones=%0d, required 1 0", tx_ready, done_cnt - d0);
        else n_pass++;
        mon_en = 1'b1;
        send(9'h0C3, 8, PAR_EVEN, 1'b0, 1'b0);
        wait_done("abort_next");
        check_drained("abort_next");
    endtask

    task automatic test_async_reset();
        int d0;
        mon_en = 1'b0;
        send(9'h0AA, 8, PAR_ODD, 1'b1, 1'b1);
        exp_q.delete();
        repeat (60) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0)
            $display("FAIL async_reset: tx=%0b busy=%0b ready=%0b, required 1 0 0", tx, busy, tx_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        d0    = done_cnt;
        repeat (250) @(negedge clk);
        n_checks++;
        if (done_cnt != d0 || busy !== 1'b0) $display("FAIL async_reset_quiet: dones=%0d busy=%0b, required 0 0", done_cnt - d0, busy);
        else n_pass++;
        mon_en = 1'b1;
    endtask

    // Second character waits while the first is in flight and is taken the cycle after DONE.
    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        send(9'h0E7, 8, PAR_EVEN, 1'b0, 1'b1);
        send(9'h118, 9, PAR_NONE, 1'b1, 1'b0);
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL b2b_gap: %0d dones before second accept, required 1", done_cnt - d0);
        else n_pass++;
        wait_done("b2b");
        check_drained("b2b");
    endtask

`ifdef UART_TX_BREAK_EN
    // Break at 8N1: 10 low ticks, one stop tick, done; the coincident tx_valid goes out afterwards.
    task automatic test_break();
        int n;
        @(negedge clk);
        while (!(tx_ready && div == 4'd15)) @(negedge clk);
        for (int i = 0; i < 10; i++) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        data_in       = 9'h05A;
        cfg_data_bits = 4'd8;
        cfg_parity    = PAR_NONE;
        cfg_stop2     = 1'b0;
        send_break    = 1'b1;
        tx_valid      = 1'b1;
        push_frame(9'h05A, 8, PAR_NONE, 1'b0);
        repeat (3) @(negedge clk);
        send_break = 1'b0;
        n_checks++;
        if (tx !== 1'b0 || tx_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL break_hold: tx=%0b ready=%0b busy=%0b, required 0 0 1", tx, tx_ready, busy);
        else n_pass++;
        wait_done("break");
        n = 0;
        while (n < 10 && !tx_ready) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        wait_done("break_next");
        check_drained("break");
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_8n1();
        test_formats();
        test_cfg_midframe();
        test_abort();
        test_async_reset();
        test_back_to_back();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
